gpr_file: RTL
=============

// Module: gpr_file
// PURPOSE
//  General-purpose register file: the storage end of Register_file_if GPR traffic.
//  - 32 x Word entries; three async read ports (a/b/c); two write ports (dest, dest_2).
//  - Read-after-write bypass and a sequenced zero-clear engine that runs after reset or on request.
//  - Sits beside the SPR/branch registers inside the register-file top; driven by the write-back stage.
// PARAMETERS
//  SINGLE_WRITE_PORT  1'b0  1: ignore gpr_we_2/gpr_sel_dest_2/gpr_dest_2 (port 2 tied off internally)
//  BYPASS             1'b1  1: read ports return same-cycle write data; 0: read returns stored value
//  CLEAR_ON_RESET     1'b1  1: clear engine starts when reset deasserts; 0: only on clear_req
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  reset           in   1   synchronous, active-high reset
//  gpr_sel_a/b/c   in   5   Reg_index, read selects
//  gpr_a/b/c       out  32  Word, read data
//  gpr_sel_dest    in   5   write port 1 index
//  gpr_we          in   1   write port 1 enable
//  gpr_dest        in   32  write port 1 data
//  gpr_sel_dest_2  in   5   write port 2 index
//  gpr_we_2        in   1   write port 2 enable
//  gpr_dest_2      in   32  write port 2 data
//  clear_req       in   1   pulse: start zero-clear of all 32 entries
//  clear_busy      out  1   clear engine active
//  clear_done      out  1   1-cycle pulse on last cleared entry
// BEHAVIOUR
//  - Reset: FSM->(CLEAR_ON_RESET ? CLEAR : IDLE); clr_idx=0; clear_busy=CLEAR_ON_RESET on the cycle after
//    reset, clear_done=0. Array contents are not reset (the clear engine does it).
//    Reset mid-clear restarts at index 0.
//  - Write: entry[sel] <= data on clk when we=1; write latency 1 cycle.
//  - Dual write, same index: port 1 (gpr_we/gpr_dest) wins; port 2 write to that index dropped.
//  - Read: combinational. BYPASS=1: if gpr_we && sel==gpr_sel_dest -> gpr_dest; else if gpr_we_2 &&
//    sel==gpr_sel_dest_2 -> gpr_dest_2; else entry[sel]. Same port-1 priority as storage.
//  - No hardwired zero register (r0 is an ordinary GPR).
//  - FSM: IDLE --clear_req--> CLEAR; CLEAR: each cycle entry[clr_idx] <= 0, clr_idx++.
//    At clr_idx==31: clear_done=1 for that cycle; FSM->IDLE; clr_idx wraps to 0.
//    Full clear = exactly 32 cycles with clear_busy=1.
//  - Writes during CLEAR are accepted; a port write to clr_idx in the same cycle overrides the clear
//    (write data stored). Writes to not-yet-cleared entries are later zeroed by the engine.
//  - clear_req while busy: ignored (no restart). clear_req in the same cycle as reset: reset wins.
//  - Reads during CLEAR return current array/bypass value; the clear is not bypassed.
//  - SINGLE_WRITE_PORT=1: port-2 inputs have no effect on storage or bypass.
// STRUCTURE
//  - Reg_index and Word come from Pu_types.
//  - Add to Pu_types: typedef enum logic {GPR_CLR_IDLE, GPR_CLR_RUN} Gpr_clr_state;
//    localparam int GPR_COUNT = 32.
//  - One sub-module: gpr_file_bypass (combinational read mux + priority), instantiated 3x.
//  - Clear FSM + counter and array inline.
// TESTING
//  1 reset, CLEAR_ON_RESET=1 -> clear_busy=1 for 32 cycles, clear_done pulse on cycle 32;
//    all 32 reads == 0.
//  2 write r5=32'hDEADBEEF via port 1 -> same-cycle gpr_a(sel=5)==DEADBEEF (BYPASS=1);
//    next cycle gpr_a still DEADBEEF.
//  3 port1 r7=32'h1, port2 r7=32'h2 same cycle -> bypass and stored r7==32'h1;
//    port2 r8=32'h3 alone -> r8==3.
//  4 clear_req; at clr_idx==10 write r10=32'hA5A5A5A5 -> after done r10==A5A5A5A5;
//    r20 written at idx 10 -> r20==0 after done.
//  5 reset asserted at clr_idx==17 -> engine restarts at 0; clear_done only after 32 further cycles.
//  6 SINGLE_WRITE_PORT=1: gpr_we_2=1 r3=32'hFF -> r3 unchanged (0); BYPASS=0: same-cycle read of
//    written index returns old value.

Source files
------------

// File: rtl/gpr_file_pkg.sv
// Shared types for the GPR file: register index, data word, clear-engine state.
package gpr_file_pkg;
  localparam int GPR_COUNT = 32;

  typedef logic [4:0]  Reg_index;
  typedef logic [31:0] Word;

  typedef enum logic {GPR_CLR_IDLE, GPR_CLR_RUN} Gpr_clr_state;
endpackage

// File: rtl/gpr_file_bypass.sv
// Read-port mux for one GPR read port.
//   sel_i      : read index
//   stored_i   : array contents at sel_i
//   we_i/sel_dest_i/dest_i    : write port 1 (highest priority)
//   we2_i/sel_dest2_i/dest2_i : write port 2
//   rdata_o    : read data (stored value, or same-cycle write data when BYPASS=1)
module gpr_file_bypass #(
  parameter bit BYPASS = 1'b1
) (
  input  logic [4:0]  sel_i,
  input  logic [31:0] stored_i,
  input  logic        we_i,
  input  logic [4:0]  sel_dest_i,
  input  logic [31:0] dest_i,
  input  logic        we2_i,
  input  logic [4:0]  sel_dest2_i,
  input  logic [31:0] dest2_i,
  output logic [31:0] rdata_o
);
  // Port 1 is checked first so the forwarded value matches what storage keeps.
  always_comb begin
    rdata_o = stored_i;
    if (BYPASS) begin
      if (we_i && sel_i == sel_dest_i)        rdata_o = dest_i;
      else if (we2_i && sel_i == sel_dest2_i) rdata_o = dest2_i;
    end
  end
endmodule

// File: rtl/gpr_file.sv
// 32 x 32-bit general-purpose register file with three async read ports,
// two write ports (port 1 wins on index collision) and a sequenced zero-clear engine.
//   clk, reset                  : clock, synchronous active-high reset
//   gpr_sel_a/b/c, gpr_a/b/c    : read selects / read data
//   gpr_we, gpr_sel_dest, gpr_dest        : write port 1
//   gpr_we_2, gpr_sel_dest_2, gpr_dest_2  : write port 2
//   clear_req                   : start a full zero-clear (ignored while busy)
//   clear_busy, clear_done      : engine active / pulse while clearing the last entry
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter bit SINGLE_WRITE_PORT = 1'b0,
  parameter bit BYPASS            = 1'b1,
  parameter bit CLEAR_ON_RESET    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  gpr_sel_a,
  input  logic [4:0]  gpr_sel_b,
  input  logic [4:0]  gpr_sel_c,
  output logic [31:0] gpr_a,
  output logic [31:0] gpr_b,
  output logic [31:0] gpr_c,
  input  logic [4:0]  gpr_sel_dest,
  input  logic        gpr_we,
  input  logic [31:0] gpr_dest,
  input  logic [4:0]  gpr_sel_dest_2,
  input  logic        gpr_we_2,
  input  logic [31:0] gpr_dest_2,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done
);
  localparam int NUM_RD = 3;
  localparam logic [4:0] LAST_IDX = 5'(GPR_COUNT - 1);

  Word          mem_q [GPR_COUNT];
  Gpr_clr_state state_q;
  Reg_index     clr_idx_q;

  logic we2_eff;
  logic clr_wr;
  assign we2_eff = gpr_we_2 & ~SINGLE_WRITE_PORT;
  assign clr_wr  = (state_q == GPR_CLR_RUN) & ~reset;

  // Clear engine: one entry per cycle, done pulse on the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? GPR_CLR_RUN : GPR_CLR_IDLE;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        GPR_CLR_IDLE: begin
          clr_idx_q <= '0;
          if (clear_req) state_q <= GPR_CLR_RUN;
        end
        GPR_CLR_RUN: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= GPR_CLR_IDLE;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 5'd1;
          end
        end
        default: begin
          state_q   <= GPR_CLR_IDLE;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  assign clear_busy = (state_q == GPR_CLR_RUN);
  assign clear_done = (state_q == GPR_CLR_RUN) && (clr_idx_q == LAST_IDX);

  // Later assignments win: clear < port 2 < port 1.
  always_ff @(posedge clk) begin
    if (clr_wr)  mem_q[clr_idx_q]      <= '0;
    if (we2_eff) mem_q[gpr_sel_dest_2] <= gpr_dest_2;
    if (gpr_we)  mem_q[gpr_sel_dest]   <= gpr_dest;
  end

  logic [NUM_RD-1:0][4:0]  rd_sel;
  logic [NUM_RD-1:0][31:0] rd_data;
  assign rd_sel = {gpr_sel_c, gpr_sel_b, gpr_sel_a};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    gpr_file_bypass #(.BYPASS(BYPASS)) u_byp (
      .sel_i       (rd_sel[g]),
      .stored_i    (mem_q[rd_sel[g]]),
      .we_i        (gpr_we),
      .sel_dest_i  (gpr_sel_dest),
      .dest_i      (gpr_dest),
      .we2_i       (we2_eff),
      .sel_dest2_i (gpr_sel_dest_2),
      .dest2_i     (gpr_dest_2),
      .rdata_o     (rd_data[g])
    );
  end

  assign gpr_a = rd_data[0];
  assign gpr_b = rd_data[1];
  assign gpr_c = rd_data[2];
endmodule
